// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: abc_defg patterns and the pattern -> {err, value} decoder
// used by both the display driver side and the scan capture side.
package seg7_pkg;

  localparam int SEG7_W = 7;

  localparam logic [SEG7_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG7_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG7_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG7_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG7_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG7_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG7_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG7_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG7_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG7_W-1:0] SEG_9 = 7'b1110011;
  localparam logic [SEG7_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG7_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG7_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG7_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG7_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG7_W-1:0] SEG_F = 7'b1000111;

  // Exact-match decode; returns {err, val}. Undecodable patterns (blank included) give {1, 4'hF}.
  function automatic logic [4:0] seg7_decode(input logic [SEG7_W-1:0] seg, input logic hex_en);
    logic [4:0] r;
    r = 5'h1F;
    case (seg)
      SEG_0: r = 5'h00;
      SEG_1: r = 5'h01;
      SEG_2: r = 5'h02;
      SEG_3: r = 5'h03;
      SEG_4: r = 5'h04;
      SEG_5: r = 5'h05;
      SEG_6: r = 5'h06;
      SEG_7: r = 5'h07;
      SEG_8: r = 5'h08;
      SEG_9: r = 5'h09;
      SEG_A: if (hex_en) r = 5'h0A;
      SEG_B: if (hex_en) r = 5'h0B;
      SEG_C: if (hex_en) r = 5'h0C;
      SEG_D: if (hex_en) r = 5'h0D;
      SEG_E: if (hex_en) r = 5'h0E;
      SEG_F: if (hex_en) r = 5'h0F;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern decoder. Define SEG7_HEX_EN to accept the A..F glyphs;
// otherwise they decode as invalid.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG7_W-1:0] seg,
  output logic [3:0]        val,
  output logic              err
);

`ifdef SEG7_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  assign {err, val} = seg7_decode(seg, HEX_EN);

endmodule

// File: rtl/seg7_scan_capture.sv
// Display-side monitor for a multiplexed 7-segment bus: waits for a stable lit digit, decodes it
// and holds one value per position. Build option SEG7_HEX_EN enables A..F decode.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEG7_W-1:0]             seg_i,
  input  logic [NUM_DIGITS-1:0]         an_i,
  output logic [4*NUM_DIGITS-1:0]       digits_o,
  output logic [NUM_DIGITS-1:0]         digit_vld_o,
  output logic [NUM_DIGITS-1:0]         digit_err_o,
  output logic                          upd_o,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx_o,
  output logic                          frame_o,
  output logic                          bus_err_o
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

  logic [SEG7_W-1:0]           seg_q, seg_p;
  logic [NUM_DIGITS-1:0]       an_q, an_p;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic                        lit, multi, same, capture;
  logic [IW-1:0]               idx;
  logic [NUM_DIGITS-1:0]       seen, seen_set, idx_mask;
  logic [3:0]                  dec_val;
  logic                        dec_err;
  logic [NUM_DIGITS-1:0][3:0]  digits;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_q[i]) idx = IW'(i);
  end

  assign lit   = $onehot(~an_q);
  assign multi = !$onehot0(~an_q);
  assign same  = (seg_q == seg_p) && (an_q == an_p);

  // Any change or dark/bus-error sample restarts the run; a new lit sample counts as the first.
  always_comb begin
    cnt_nxt = '0;
    if (lit) begin
      if (!same)              cnt_nxt = CW'(1);
      else if (cnt == CNT_MAX) cnt_nxt = cnt;
      else                     cnt_nxt = cnt + CW'(1);
    end
  end

  assign capture  = lit && same && (cnt == CNT_PRE);
  assign idx_mask = NUM_DIGITS'(1) << idx;
  assign seen_set = seen | idx_mask;
  assign bus_err_o = multi;

  seg7_pattern_decode u_dec (
    .seg (seg_q),
    .val (dec_val),
    .err (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      seg_p     <= '0;
      an_q      <= '1;
      an_p      <= '1;
      cnt       <= '0;
      seen      <= '0;
      upd_o     <= 1'b0;
      upd_idx_o <= '0;
      frame_o   <= 1'b0;
    end else begin
      seg_q   <= seg_i;
      an_q    <= an_i;
      seg_p   <= seg_q;
      an_p    <= an_q;
      cnt     <= cnt_nxt;
      upd_o   <= capture;
      frame_o <= 1'b0;
      if (capture) begin
        upd_idx_o <= idx;
        if (&seen_set) begin
          frame_o <= 1'b1;
          seen    <= '0;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    always_ff @(posedge clk) begin
      if (rst) begin
        digits[g]      <= '0;
        digit_err_o[g] <= 1'b0;
        digit_vld_o[g] <= 1'b0;
      end else if (capture && idx == IW'(g)) begin
        digits[g]      <= dec_val;
        digit_err_o[g] <= dec_err;
        digit_vld_o[g] <= 1'b1;
      end
    end
  end

  assign digits_o = digits;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_seg7_scan_capture;

  localparam int N  = 4;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   seg_i;
  logic [N-1:0] an_i;
  logic [4*N-1:0] digits_o;
  logic [N-1:0] digit_vld_o, digit_err_o;
  logic         upd_o, frame_o, bus_err_o;
  logic [1:0]   upd_idx_o;

  seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_i(seg_i), .an_i(an_i),
    .digits_o(digits_o), .digit_vld_o(digit_vld_o), .digit_err_o(digit_err_o),
    .upd_o(upd_o), .upd_idx_o(upd_idx_o), .frame_o(frame_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [3:0] val; logic err; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int upd_cnt = 0, frame_cnt = 0, bus_cnt = 0, frame_idx = -1;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101, P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011, P5 = 7'b1011011, P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111, P9 = 7'b1110011, PA = 7'b1110111;

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
    for (int i = 0; i < 10; i++) if (s == tbl[i]) return {1'b0, 4'(i)};
`ifdef SEG7_HEX_EN
    if (s == 7'b1110111) return 5'h0A;
    if (s == 7'b0011111) return 5'h0B;
    if (s == 7'b1001110) return 5'h0C;
    if (s == 7'b0111101) return 5'h0D;
    if (s == 7'b1001111) return 5'h0E;
    if (s == 7'b1000111) return 5'h0F;
`endif
    return 5'h1F;
  endfunction

  function automatic int lit_idx(input logic [N-1:0] an);
    int nz = 0, ix = -1;
    for (int i = 0; i < N; i++) if (!an[i]) begin nz++; ix = i; end
    return (nz == 1) ? ix : -1;
  endfunction

  function automatic void expect_cap(input logic [N-1:0] an, input logic [6:0] s);
    exp_t e;
    logic [4:0] d;
    d = ref_dec(s);
    e.idx = lit_idx(an);
    e.val = d[3:0];
    e.err = d[4];
    q.push_back(e);
  endfunction

  // Monitor: every upd_o pops the scoreboard; frame_o must coincide with upd_o.
  always @(negedge clk) begin
    if (bus_err_o) bus_cnt++;
    if (frame_o) begin
      frame_cnt++;
      frame_idx = int'(upd_idx_o);
      checks++;
      if (!upd_o) begin errors++; $display("FAIL frame_without_upd got upd=%0b exp 1", upd_o); end
    end
    if (upd_o) begin
      upd_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL unexpected_upd idx=%0d", upd_idx_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(upd_idx_o) !== e.idx || digits_o[e.idx*4 +: 4] !== e.val ||
            digit_err_o[e.idx] !== e.err || digit_vld_o[e.idx] !== 1'b1) begin
          errors++;
          $display("FAIL capture got idx=%0d val=%h err=%0b vld=%0b exp idx=%0d val=%h err=%0b vld=1",
                   upd_idx_o, digits_o[e.idx*4 +: 4], digit_err_o[e.idx], digit_vld_o[e.idx],
                   e.idx, e.val, e.err);
        end
      end
    end
  end

  task automatic hold(input logic [N-1:0] an, input logic [6:0] s, input int n);
    if (n >= SC && lit_idx(an) >= 0) expect_cap(an, s);
    an_i = an; seg_i = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    hold('1, 7'b0, 3);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL %s_missing_capture got pending=%0d exp 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; an_i = '1; seg_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({digits_o, digit_vld_o, digit_err_o, upd_o, upd_idx_o, frame_o, bus_err_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got digits=%h vld=%b err=%b upd=%b exp all 0",
                         digits_o, digit_vld_o, digit_err_o, upd_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int lat = 0, u0;
    u0 = upd_cnt;
    expect_cap(4'b1110, P2);
    an_i = 4'b1110; seg_i = P2;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      if (upd_o && lat == 0) lat = k;
    end
    checks++;
    if (lat != SC + 1) begin errors++; $display("FAIL single_latency got %0d exp %0d", lat, SC + 1); end
    drain("single");
    checks++;
    if (digits_o[3:0] !== 4'h2) begin errors++; $display("FAIL single_value got %h exp 2", digits_o[3:0]); end
    checks++;
    if (upd_cnt - u0 != 1) begin errors++; $display("FAIL single_upd_count got %0d exp 1", upd_cnt - u0); end
  endtask

  task automatic test_scan;
    int u0, f0;
    u0 = upd_cnt; f0 = frame_cnt;
    hold(4'b1110, P5, 8);
    hold(4'b1101, P0, 8);
    hold(4'b1011, P7, 8);
    hold(4'b0111, P9, 8);
    drain("scan");
    checks++;
    if (digits_o !== 16'h9705) begin errors++; $display("FAIL scan_digits got %h exp 9705", digits_o); end
    checks++;
    if (digit_vld_o !== 4'hF) begin errors++; $display("FAIL scan_vld got %b exp 1111", digit_vld_o); end
    checks++;
    if (upd_cnt - u0 != 4) begin errors++; $display("FAIL scan_upd_count got %0d exp 4", upd_cnt - u0); end
    checks++;
    if (frame_cnt - f0 != 1 || frame_idx != 3) begin
      errors++; $display("FAIL scan_frame got count=%0d idx=%0d exp 1 / 3", frame_cnt - f0, frame_idx);
    end
  endtask

  task automatic test_short;
    int u0;
    u0 = upd_cnt;
    hold(4'b1101, P3, SC - 1);
    hold(4'b1011, P4, 6);
    drain("short");
    checks++;
    if (upd_cnt - u0 != 1) begin errors++; $display("FAIL short_upd_count got %0d exp 1", upd_cnt - u0); end
    checks++;
    if (digits_o[7:4] !== 4'h0) begin errors++; $display("FAIL short_digit1 got %h exp 0", digits_o[7:4]); end
  endtask

  task automatic test_bus_err;
    int u0, b0;
    u0 = upd_cnt; b0 = bus_cnt;
    hold(4'b1100, P8, 5);
    hold('1, P8, 1);
    checks++;
    if (bus_cnt - b0 != 5) begin errors++; $display("FAIL bus_err_count got %0d exp 5", bus_cnt - b0); end
    b0 = bus_cnt;
    hold(4'b1111, P1, 5);
    checks++;
    if (bus_cnt - b0 != 0) begin errors++; $display("FAIL dark_bus_err got %0d exp 0", bus_cnt - b0); end
    checks++;
    if (upd_cnt - u0 != 0) begin errors++; $display("FAIL bus_upd_count got %0d exp 0", upd_cnt - u0); end
  endtask

  task automatic test_invalid;
    logic [4:0] ea;
    hold(4'b1101, 7'b0000000, 6);
    hold(4'b1101, PA, 6);
    drain("invalid");
    ea = ref_dec(PA);
    checks++;
    if (digits_o[7:4] !== ea[3:0] || digit_err_o[1] !== ea[4]) begin
      errors++; $display("FAIL invalid_digit1 got val=%h err=%0b exp val=%h err=%0b",
                         digits_o[7:4], digit_err_o[1], ea[3:0], ea[4]);
    end
  endtask

  task automatic test_rst_mid;
    an_i = 4'b1011; seg_i = P8;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({digits_o, digit_vld_o, digit_err_o, upd_o, frame_o} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got digits=%h vld=%b err=%b upd=%b exp 0",
                         digits_o, digit_vld_o, digit_err_o, upd_o);
    end
    rst = 1'b0;
    hold(4'b1011, P8, 6);
    drain("rst_mid");
    checks++;
    if (digits_o !== 16'h0800 || digit_vld_o !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_recapture got digits=%h vld=%b exp 0800 / 0100", digits_o, digit_vld_o);
    end
  endtask

  task automatic test_back_to_back;
    int u0;
    u0 = upd_cnt;
    hold(4'b1110, P1, 6);
    hold(4'b1101, P1, 6);
    hold(4'b1110, P1, 6);
    drain("b2b");
    checks++;
    if (upd_cnt - u0 != 3) begin errors++; $display("FAIL b2b_upd_count got %0d exp 3", upd_cnt - u0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_scan;
    test_short;
    test_bus_err;
    test_invalid;
    test_rst_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
